// File: rtl/accel_uart_rx.sv
// accel_uart_rx: UART1 receive path. Synchronises the pad line, deserialises
// 8N1 / 8P1 frames and stores good bytes in a fall-through FIFO with a
// valid/ready pop port. Frame, parity and overflow errors are 1-cycle pulses.
module accel_uart_rx #(
  parameter int unsigned log2_fifosz = 4
) (
  input  logic                   i_clk,
  input  logic                   i_nrst,
  input  logic                   i_rx_en,
  input  logic [15:0]            i_scaler,
  input  logic                   i_parity_en,
  input  logic                   i_parity_odd,
  input  logic                   i_rd,
  output logic [7:0]             o_rdata,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  output logic [log2_fifosz:0]   o_fifo_cnt,
  output logic                   o_err_frame,
  output logic                   o_err_parity,
  output logic                   o_err_overflow
);

  localparam int unsigned PTR_W = log2_fifosz;
  localparam int unsigned CNT_W = log2_fifosz + 1;
  localparam int unsigned DEPTH = 1 << log2_fifosz;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state;
  logic               rx_meta;
  logic               rx_s;
  logic               rx_prev;
  logic [15:0]        clk_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               par_err;

  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               fall_c;
  logic               rx_on_c;
  logic [15:0]        target_c;
  logic               tick_c;
  logic               push_c;
  logic               pop_c;
  logic               full_c;
  logic               wr_en_c;

  // Two-flop synchroniser plus previous-value flop for falling-edge detect
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Bit timing: half a bit in START to land mid-bit, full bits afterwards
  always_comb begin
    fall_c   = rx_prev & ~rx_s;
    rx_on_c  = i_rx_en && (i_scaler >= 16'd4);
    target_c = (state == S_START) ? (i_scaler >> 1) : i_scaler;
    tick_c   = (clk_cnt >= (target_c - 16'd1));
    push_c   = rx_on_c && (state == S_STOP) && tick_c && rx_s && !par_err;
  end

  // Receive FSM; error pulses are registered from the stop-bit sample
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= S_IDLE;
      clk_cnt      <= 16'd0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'd0;
      par_err      <= 1'b0;
      o_err_frame  <= 1'b0;
      o_err_parity <= 1'b0;
    end else begin
      o_err_frame  <= 1'b0;
      o_err_parity <= 1'b0;
      if (!rx_on_c) begin
        state   <= S_IDLE;
        clk_cnt <= 16'd0;
      end else begin
        case (state)
          S_IDLE: begin
            clk_cnt <= 16'd0;
            if (fall_c) begin
              state   <= S_START;
              bit_cnt <= 3'd0;
              par_err <= 1'b0;
            end
          end
          S_START: begin
            if (tick_c) begin
              clk_cnt <= 16'd0;
              state   <= rx_s ? S_IDLE : S_DATA;
            end else begin
              clk_cnt <= clk_cnt + 16'd1;
            end
          end
          S_DATA: begin
            if (tick_c) begin
              clk_cnt <= 16'd0;
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= i_parity_en ? S_PARITY : S_STOP;
              end
            end else begin
              clk_cnt <= clk_cnt + 16'd1;
            end
          end
          S_PARITY: begin
            if (tick_c) begin
              clk_cnt <= 16'd0;
              par_err <= (rx_s != ((^shreg) ^ i_parity_odd));
              state   <= S_STOP;
            end else begin
              clk_cnt <= clk_cnt + 16'd1;
            end
          end
          S_STOP: begin
            if (tick_c) begin
              clk_cnt <= 16'd0;
              state   <= S_IDLE;
              if (!rx_s) begin
                o_err_frame <= 1'b1;
              end else if (par_err) begin
                o_err_parity <= 1'b1;
              end
            end else begin
              clk_cnt <= clk_cnt + 16'd1;
            end
          end
          default: begin
            state   <= S_IDLE;
            clk_cnt <= 16'd0;
          end
        endcase
      end
    end
  end

  // FIFO control decode; a full FIFO still accepts a push if the head pops
  always_comb begin
    pop_c   = (count != '0) && i_rready;
    full_c  = (count == CNT_W'(DEPTH));
    wr_en_c = push_c && (!full_c || pop_c);
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_err_overflow <= 1'b0;
    end else begin
      o_err_overflow <= push_c && full_c && !pop_c;
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Byte storage; contents are only visible through the gated head
  always_ff @(posedge i_clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= shreg;
    end
  end

  // Fall-through head, forced to zero when empty
  always_comb begin
    o_rvalid   = (count != '0);
    o_rdata    = o_rvalid ? mem[rd_ptr] : 8'h00;
    o_fifo_cnt = count;
  end

endmodule

// File: tb/tb_accel_uart_rx.sv
// Bench for accel_uart_rx: sends frames on the serial line, records expected
// bytes in a scoreboard queue and checks them as the FIFO is drained.
module tb_accel_uart_rx;

  localparam int unsigned LOG2 = 4;
  localparam int unsigned SCALER = 8;

  logic             i_clk;
  logic             i_nrst;
  logic             i_rx_en;
  logic [15:0]      i_scaler;
  logic             i_parity_en;
  logic             i_parity_odd;
  logic             i_rd;
  logic [7:0]       o_rdata;
  logic             o_rvalid;
  logic             i_rready;
  logic [LOG2:0]    o_fifo_cnt;
  logic             o_err_frame;
  logic             o_err_parity;
  logic             o_err_overflow;

  int checks;
  int failures;
  int n_frame;
  int n_par;
  int n_ovf;
  logic [7:0] exp_q [$];

  accel_uart_rx #(.log2_fifosz(LOG2)) dut (
    .i_clk          (i_clk),
    .i_nrst         (i_nrst),
    .i_rx_en        (i_rx_en),
    .i_scaler       (i_scaler),
    .i_parity_en    (i_parity_en),
    .i_parity_odd   (i_parity_odd),
    .i_rd           (i_rd),
    .o_rdata        (o_rdata),
    .o_rvalid       (o_rvalid),
    .i_rready       (i_rready),
    .o_fifo_cnt     (o_fifo_cnt),
    .o_err_frame    (o_err_frame),
    .o_err_parity   (o_err_parity),
    .o_err_overflow (o_err_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Error pulse counters, sampled away from the active edge
  always @(negedge i_clk) begin
    if (o_err_frame)    n_frame++;
    if (o_err_parity)   n_par++;
    if (o_err_overflow) n_ovf++;
  end

  task automatic wait_bit();
    repeat (SCALER) @(posedge i_clk);
    #1;
  endtask

  task automatic align();
    @(posedge i_clk);
    #1;
  endtask

  // Drives one frame; must be entered just after a rising edge
  task automatic send_frame(input logic [7:0] b, input logic par_bit, input logic stop_bit);
    i_rd = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      i_rd = b[i];
      wait_bit();
    end
    if (i_parity_en) begin
      i_rd = par_bit;
      wait_bit();
    end
    i_rd = stop_bit;
    wait_bit();
    i_rd = 1'b1;
    repeat (2 * SCALER) @(posedge i_clk);
    #1;
  endtask

  // Scoreboard consumer: pops every byte and compares it with the queue head
  task automatic drain(input string tag);
    logic [7:0] e;
    int guard;
    guard = 0;
    while (o_rvalid && guard < 64) begin
      @(negedge i_clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_extra_byte got=%02h expected none", tag, o_rdata);
      end else begin
        e = exp_q.pop_front();
        if (o_rdata !== e) begin
          failures++;
          $display("FAIL %s_data got=%02h expected=%02h", tag, o_rdata, e);
        end
      end
      i_rready = 1'b1;
      @(posedge i_clk);
      #1;
      i_rready = 1'b0;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing got=%0d_left expected=0_left", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (o_rvalid !== 1'b0)  begin failures++; $display("FAIL reset_rvalid got=%b expected=0", o_rvalid); end
    checks++; if (o_rdata !== 8'h00)  begin failures++; $display("FAIL reset_rdata got=%02h expected=00", o_rdata); end
    checks++; if (o_fifo_cnt !== '0)  begin failures++; $display("FAIL reset_cnt got=%0d expected=0", o_fifo_cnt); end
    checks++; if ({o_err_frame, o_err_parity, o_err_overflow} !== 3'b000) begin
      failures++; $display("FAIL reset_errs got=%b expected=000", {o_err_frame, o_err_parity, o_err_overflow});
    end
    align();
    i_nrst = 1'b1;
    repeat (4) align();
  endtask

  task automatic test_basic();
    int lat;
    lat = 0;
    exp_q.push_back(8'hA5);
    align();
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        while (lat < 200) begin
          @(posedge i_clk);
          lat++;
          #1;
          if (o_rvalid) break;
        end
      end
    join
    checks++;
    if (lat < 78 || lat > 82) begin
      failures++; $display("FAIL basic_latency got=%0d expected=78..82", lat);
    end
    checks++; if (o_rdata !== 8'hA5) begin failures++; $display("FAIL basic_head got=%02h expected=a5", o_rdata); end
    checks++; if (o_fifo_cnt !== 5'd1) begin failures++; $display("FAIL basic_cnt got=%0d expected=1", o_fifo_cnt); end
    drain("basic");
    checks++; if (o_fifo_cnt !== 5'd0) begin failures++; $display("FAIL basic_cnt_after_pop got=%0d expected=0", o_fifo_cnt); end
    checks++; if (o_rdata !== 8'h00) begin failures++; $display("FAIL basic_rdata_empty got=%02h expected=00", o_rdata); end
  endtask

  task automatic test_parity();
    int p0;
    int f0;
    p0 = n_par;
    f0 = n_frame;
    i_parity_en  = 1'b1;
    i_parity_odd = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    checks++; if (n_par - p0 != 1) begin failures++; $display("FAIL parity_err_pulses got=%0d expected=1", n_par - p0); end
    checks++; if (o_fifo_cnt !== 5'd1) begin failures++; $display("FAIL parity_cnt got=%0d expected=1", o_fifo_cnt); end
    i_parity_odd = 1'b1;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    checks++; if (o_fifo_cnt !== 5'd2) begin failures++; $display("FAIL parity_odd_cnt got=%0d expected=2", o_fifo_cnt); end
    checks++; if (n_par - p0 != 1 || n_frame != f0) begin
      failures++; $display("FAIL parity_odd_errs got=%0d/%0d expected=1/0", n_par - p0, n_frame - f0);
    end
    drain("parity");
    i_parity_en  = 1'b0;
    i_parity_odd = 1'b0;
  endtask

  task automatic test_frame_err();
    int f0;
    int p0;
    f0 = n_frame;
    p0 = n_par;
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++; if (n_frame - f0 != 1) begin failures++; $display("FAIL frame_err_pulses got=%0d expected=1", n_frame - f0); end
    checks++; if (n_par != p0) begin failures++; $display("FAIL frame_par_pulses got=%0d expected=0", n_par - p0); end
    checks++; if (o_fifo_cnt !== 5'd0) begin failures++; $display("FAIL frame_cnt got=%0d expected=0", o_fifo_cnt); end
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1);
    checks++; if (o_fifo_cnt !== 5'd1) begin failures++; $display("FAIL frame_recover_cnt got=%0d expected=1", o_fifo_cnt); end
    drain("frame");
  endtask

  task automatic test_overflow();
    int o0;
    o0 = n_ovf;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b1);
    end
    checks++; if (o_fifo_cnt !== 5'd16) begin failures++; $display("FAIL ovf_cnt got=%0d expected=16", o_fifo_cnt); end
    checks++; if (n_ovf - o0 != 1) begin failures++; $display("FAIL ovf_pulses got=%0d expected=1", n_ovf - o0); end
    drain("ovf");
    o0 = n_ovf;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b1);
    end
    exp_q.push_back(8'h10);
    fork
      send_frame(8'h10, 1'b0, 1'b1);
      begin
        repeat (78) @(posedge i_clk);
        #1;
        i_rready = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_rdata !== exp_q[0]) begin
          failures++; $display("FAIL ovf_pop_head got=%02h expected=%02h", o_rdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(posedge i_clk);
        #1;
        i_rready = 1'b0;
      end
    join
    checks++; if (o_fifo_cnt !== 5'd16) begin failures++; $display("FAIL ovf_pop_cnt got=%0d expected=16", o_fifo_cnt); end
    checks++; if (n_ovf != o0) begin failures++; $display("FAIL ovf_pop_pulses got=%0d expected=0", n_ovf - o0); end
    drain("ovf_pop");
  endtask

  task automatic test_glitch_disable();
    int f0;
    int p0;
    f0 = n_frame;
    p0 = n_par;
    i_rd = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rd = 1'b1;
    repeat (40) align();
    checks++; if (o_fifo_cnt !== 5'd0) begin failures++; $display("FAIL glitch_cnt got=%0d expected=0", o_fifo_cnt); end
    fork
      send_frame(8'hF0, 1'b0, 1'b1);
      begin
        repeat (44) @(posedge i_clk);
        #1;
        i_rx_en = 1'b0;
        repeat (16) @(posedge i_clk);
        #1;
        i_rx_en = 1'b1;
      end
    join
    repeat (100) align();
    checks++; if (o_fifo_cnt !== 5'd0) begin failures++; $display("FAIL disable_cnt got=%0d expected=0", o_fifo_cnt); end
    checks++; if (n_frame != f0 || n_par != p0) begin
      failures++; $display("FAIL disable_errs got=%0d/%0d expected=0/0", n_frame - f0, n_par - p0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h40 + i));
      send_frame(8'(8'h40 + i), 1'b0, 1'b1);
    end
    checks++; if (o_fifo_cnt !== 5'd5) begin failures++; $display("FAIL rstmid_pre_cnt got=%0d expected=5", o_fifo_cnt); end
    fork
      send_frame(8'hC3, 1'b0, 1'b1);
      begin
        repeat (30) @(posedge i_clk);
        #3;
        i_nrst = 1'b0;
        #1;
        checks++; if (o_fifo_cnt !== '0) begin failures++; $display("FAIL rstmid_cnt got=%0d expected=0", o_fifo_cnt); end
        checks++; if (o_rvalid !== 1'b0 || o_rdata !== 8'h00) begin
          failures++; $display("FAIL rstmid_head got=%b/%02h expected=0/00", o_rvalid, o_rdata);
        end
        exp_q.delete();
      end
    join
    i_nrst = 1'b1;
    repeat (4) align();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++; if (o_fifo_cnt !== 5'd1) begin failures++; $display("FAIL rstmid_post_cnt got=%0d expected=1", o_fifo_cnt); end
    drain("rstmid");
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    n_frame      = 0;
    n_par        = 0;
    n_ovf        = 0;
    i_nrst       = 1'b0;
    i_rx_en      = 1'b1;
    i_scaler     = 16'(SCALER);
    i_parity_en  = 1'b0;
    i_parity_odd = 1'b0;
    i_rd         = 1'b1;
    i_rready     = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_overflow();
    test_glitch_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
